// File: rtl/mem_pkg.sv
// Shared types and geometry helpers for the mem_backend line-granular memory model.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    function automatic int line_width(input int bitsize, input int n_words);
        return bitsize * n_words;
    endfunction

    function automatic int offset_bits(input int lw);
        return $clog2(lw / 8);
    endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous line RAM with a registered read; contents are never reset.
module mem_array #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 128,
    parameter int AW    = 10
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_o <= mem_q[addr_i];
    end

endmodule

// File: rtl/mem_backend.sv
// Fixed-latency memory backend answering one outstanding line request at a time.
// Optional MEM_BACKEND_BOUNDS_CHECK_EN flags out-of-range lines instead of wrapping.
module mem_backend
    import mem_pkg::*;
#(
    parameter int BITSIZE          = 32,
    parameter int N_WORDS_PER_ADDR = 4,
    parameter int MEM_SIZE         = 1024,
    parameter int LATENCY          = 2
) (
    input  logic                                  clk,
    input  logic                                  resetn_i,
    input  logic [31:0]                           mem_addr_i,
    inout  wire  [N_WORDS_PER_ADDR*BITSIZE-1:0]   mem_data_io,
    input  logic                                  mem_store_i,
    input  logic                                  mem_valid_i,
    output logic                                  mem_valid_o,
    output logic                                  mem_err_o
);

    localparam int LW  = line_width(BITSIZE, N_WORDS_PER_ADDR);
    localparam int OFF = offset_bits(LW);
    localparam int AW  = $clog2(MEM_SIZE);
    localparam int CW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic            store_q, store_d;
    logic            oor_q, oor_d;
    logic [LW-1:0]   wdata_q, wdata_d;
    logic [LW-1:0]   rd_q, rd_d;
    logic            oe_q, oe_d;
    logic            err_q, err_d;

    logic [31:0]     line_full;
    logic [AW-1:0]   line_idx;
    logic            line_oor;
    logic            ram_we;
    logic [AW-1:0]   ram_addr;
    logic [LW-1:0]   ram_rdata;

    assign line_full = mem_addr_i >> OFF;
    assign line_idx  = line_full[AW-1:0];

`ifdef MEM_BACKEND_BOUNDS_CHECK_EN
    assign line_oor  = (line_full >= 32'(MEM_SIZE));
    assign mem_err_o = err_q;
`else
    assign line_oor  = 1'b0;
    assign mem_err_o = 1'b0;
    logic unused_err;
    assign unused_err = err_q;
`endif

    logic unused_addr;
    assign unused_addr = ^{mem_addr_i[OFF-1:0], line_full[31:AW]};

    // Reading continuously keeps the RAM one cycle ahead of the WAIT exit, even for LATENCY = 1.
    assign ram_addr = (state_q == IDLE) ? line_idx : idx_q;

    mem_array #(
        .DEPTH (MEM_SIZE),
        .WIDTH (LW),
        .AW    (AW)
    ) u_array (
        .clk     (clk),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (wdata_q),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            store_q <= 1'b0;
            oor_q   <= 1'b0;
            wdata_q <= '0;
            rd_q    <= '0;
            oe_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            store_q <= store_d;
            oor_q   <= oor_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            oe_q    <= oe_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        store_d = store_q;
        oor_d   = oor_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        oe_d    = oe_q;
        err_d   = err_q;
        ram_we  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mem_valid_i) begin
                    idx_d   = line_idx;
                    oor_d   = line_oor;
                    store_d = mem_store_i;
                    if (mem_store_i) begin
                        wdata_d = mem_data_io;
                    end
                    cnt_d   = CW'(LATENCY - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (!mem_valid_i) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    ram_we  = store_q & ~oor_q;
                    if (!store_q) begin
                        rd_d = oor_q ? '0 : ram_rdata;
                    end
                    oe_d    = ~store_q;
                    err_d   = oor_q;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (!mem_valid_i) begin
                    oe_d    = 1'b0;
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_valid_o = (state_q == RESP);
    assign mem_data_io = oe_q ? rd_q : 'z;

endmodule

// File: tb/tb_mem_backend.sv
// Directed scoreboard bench for mem_backend with default parameters.
module tb_mem_backend;

    localparam int LW       = 128;
    localparam int OFF      = 4;
    localparam int MEM_SIZE = 1024;
    localparam int LATENCY  = 2;

    logic          clk = 1'b0;
    logic          resetn_i;
    logic [31:0]   mem_addr_i;
    wire  [LW-1:0] mem_data_io;
    logic          mem_store_i;
    logic          mem_valid_i;
    logic          mem_valid_o;
    logic          mem_err_o;
    logic          tb_oe;
    logic [LW-1:0] tb_data;

    always #5 clk = ~clk;

    assign mem_data_io = tb_oe ? tb_data : 'z;

    mem_backend #(
        .BITSIZE          (32),
        .N_WORDS_PER_ADDR (4),
        .MEM_SIZE         (MEM_SIZE),
        .LATENCY          (LATENCY)
    ) dut (
        .clk         (clk),
        .resetn_i    (resetn_i),
        .mem_addr_i  (mem_addr_i),
        .mem_data_io (mem_data_io),
        .mem_store_i (mem_store_i),
        .mem_valid_i (mem_valid_i),
        .mem_valid_o (mem_valid_o),
        .mem_err_o   (mem_err_o)
    );

    typedef struct {
        logic [LW-1:0] data;
        logic          err;
        logic          store;
    } exp_t;

    exp_t          sb[$];
    logic [LW-1:0] model [MEM_SIZE];
    int            checks = 0;
    int            errors = 0;

    localparam logic [LW-1:0] D_A    = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    localparam logic [LW-1:0] D_B    = 128'hB0B0_0000_CAFE_F00D_0BAD_BEEF_1234_5678;
    localparam logic [LW-1:0] D_DEAD = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0000_0001;
    localparam logic [LW-1:0] D_C    = 128'hC0DE_C0DE_FEED_FACE_A5A5_5A5A_0F0F_F0F0;
    localparam logic [LW-1:0] D_E    = 128'hEEEE_0000_1357_9BDF_2468_ACE0_FFFF_0002;
    localparam logic [LW-1:0] D_LOST = 128'h0BAD_0BAD_0BAD_0BAD_0BAD_0BAD_0BAD_0BAD;

    function automatic int idx_of(input logic [31:0] a);
`ifdef MEM_BACKEND_BOUNDS_CHECK_EN
        return int'(a >> OFF);
`else
        return int'((a >> OFF) % MEM_SIZE);
`endif
    endfunction

    function automatic logic oor_of(input logic [31:0] a);
`ifdef MEM_BACKEND_BOUNDS_CHECK_EN
        return (a >> OFF) >= MEM_SIZE;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after mem_valid_o has dropped.
    task automatic txn(input logic [31:0] addr, input logic st, input logic [LW-1:0] wd, input int hold);
        exp_t e;
        exp_t got;
        int   lat;
        bit   seen;
        e.store = st;
        e.err   = oor_of(addr);
        if (st) begin
            e.data = '0;
            if (!e.err) model[idx_of(addr)] = wd;
        end else begin
            e.data = e.err ? '0 : model[idx_of(addr)];
        end
        sb.push_back(e);
        mem_addr_i  = addr;
        mem_store_i = st;
        mem_valid_i = 1'b1;
        tb_oe       = st;
        tb_data     = wd;
        lat  = 0;
        seen = 0;
        while (!seen && lat < 20) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                mem_addr_i = ~addr;
                tb_data    = ~wd;
            end
            if (mem_valid_o) seen = 1;
            else if (!st && e.data != '0) check("bus_quiet_wait", LW'(mem_data_io === e.data), '0);
        end
        check("resp_seen", LW'(seen), LW'(1));
        check("latency", LW'(lat - 1), LW'(LATENCY));
        got = sb.pop_front();
        check("err", LW'(mem_err_o), LW'(got.err));
        if (!got.store) check("rdata", mem_data_io, got.data);
        for (int h = 1; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", LW'(mem_valid_o), LW'(1));
            check("hold_err", LW'(mem_err_o), LW'(got.err));
            if (!got.store) check("hold_rdata", mem_data_io, got.data);
        end
        mem_valid_i = 1'b0;
        tb_oe       = 1'b0;
        @(negedge clk);
        check("release_valid", LW'(mem_valid_o), '0);
        check("release_err", LW'(mem_err_o), '0);
        if (!got.store && got.data != '0) check("bus_released", LW'(mem_data_io === got.data), '0);
    endtask

    initial begin
        resetn_i    = 1'b0;
        mem_addr_i  = '0;
        mem_store_i = 1'b0;
        mem_valid_i = 1'b0;
        tb_oe       = 1'b0;
        tb_data     = '0;
        repeat (2) @(negedge clk);
        check("reset_valid", LW'(mem_valid_o), '0);
        check("reset_err", LW'(mem_err_o), '0);
        resetn_i = 1'b1;
        @(negedge clk);

        txn(32'h0000_0040, 1'b1, D_A, 1);
        txn(32'h0000_0000, 1'b1, D_B, 1);
        txn(32'h0000_0010, 1'b1, D_DEAD, 1);
        txn(32'h0000_0010, 1'b0, '0, 5);
        txn(32'h0000_001C, 1'b0, '0, 1);
        txn(32'h0000_0040, 1'b0, '0, 2);

        // Store dropped by reset while waiting.
        mem_addr_i  = 32'h0000_0040;
        mem_store_i = 1'b1;
        mem_valid_i = 1'b1;
        tb_oe       = 1'b1;
        tb_data     = D_LOST;
        @(negedge clk);
        resetn_i    = 1'b0;
        mem_valid_i = 1'b0;
        tb_oe       = 1'b0;
        #1;
        check("rst_mid_wait_valid", LW'(mem_valid_o), '0);
        @(negedge clk);
        resetn_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_valid", LW'(mem_valid_o), '0);
        end
        txn(32'h0000_0040, 1'b0, '0, 1);

        // Load aborted in WAIT, then an immediate store.
        mem_addr_i  = 32'h0000_0010;
        mem_store_i = 1'b0;
        mem_valid_i = 1'b1;
        @(negedge clk);
        mem_valid_i = 1'b0;
        @(negedge clk);
        check("abort_valid", LW'(mem_valid_o), '0);
        txn(32'h0000_0020, 1'b1, D_C, 1);
        txn(32'h0000_0020, 1'b0, '0, 1);

        // Line MEM_SIZE: flagged with bounds checking, otherwise wraps to line 0.
        txn(32'h0000_4000, 1'b1, D_E, 1);
        txn(32'h0000_4000, 1'b0, '0, 2);
        txn(32'h0000_0000, 1'b0, '0, 1);
        txn(32'h0000_0010, 1'b0, '0, 1);

        check("sb_empty", LW'(sb.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_backend.md
# mem_backend

Line-granular memory backend that sits directly downstream of the memory controller. It answers the controller's single outstanding request (one line of N_WORDS_PER_ADDR × BITSIZE bits) after a fixed, parameterised latency, and holds its response until the controller releases the request. It stands in for main memory in simulation and small FPGA builds.

## Interface
- BITSIZE, 32: bits per word.
- N_WORDS_PER_ADDR, 4: words per line; line width LW = N_WORDS_PER_ADDR × BITSIZE.
- MEM_SIZE, 1024: depth in lines; power of two.
- LATENCY, 2: cycles from request acceptance to response; must be at least 1.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock.
- resetn_i  in  1  asynchronous active-low reset.
- mem_addr_i  in  32  byte address of the line.
- mem_data_io  inout  LW  line data. Driven by the controller on stores. Driven by this block only during a read response, otherwise 'bz.
- mem_store_i  in  1  1 = store, 0 = load.
- mem_valid_i  in  1  request valid; held high by the controller until it sees mem_valid_o.
- mem_valid_o  out  1  response valid / store done.
- mem_err_o  out  1  out-of-range access. Present only with the macro; otherwise tied to 0.

## Operation
- Line index = mem_addr_i >> log2(LW/8). Low byte-offset bits are ignored.
- FSM states:
  - IDLE: mem_valid_i = 1 latches address, store flag and (for a store) mem_data_io; loads the latency counter with LATENCY−1; goes to WAIT.
  - WAIT: counter decrements each cycle. At counter = 0 and mem_valid_i still 1:
    - store: the array is written;
    - load: the array line is captured into the read register;
    - go to RESP.
  - RESP: mem_valid_o = 1. For a load, mem_data_io = read register. Stays in RESP while mem_valid_i = 1. mem_valid_i = 0 returns to IDLE.
- Abort: mem_valid_i = 0 in WAIT returns to IDLE. No array write, no response.
- Changes to address, data or store flag after acceptance are ignored; only the latched values are used.
- The block never drives mem_data_io during a store response or in IDLE/WAIT. This avoids contention with the controller's write driver.
- Back-to-back requests: after RESP→IDLE, a new request is accepted no earlier than the cycle after mem_valid_i was seen low.
- Reset (asserted at any time, including mid-WAIT or mid-RESP):
  - state goes to IDLE; mem_valid_o = 0, mem_err_o = 0, mem_data_io = 'bz;
  - an in-flight store is dropped;
  - array contents are not reset.

## Timing
- mem_valid_i first sampled high at edge T: mem_valid_o is high after edge T+LATENCY.
- LATENCY = 1 gives a single WAIT cycle.
- Read data is valid in the same cycle mem_valid_o rises and is stable for the whole of RESP.
- A store is visible to a load accepted in any later request.
- mem_valid_o falls the cycle after mem_valid_i is sampled low.
- All outputs are registered. mem_data_io enable = (state == RESP) & ~store_latched.

## Configuration
- MEM_BACKEND_BOUNDS_CHECK_EN defined:
  - a line index ≥ MEM_SIZE is out of range;
  - an out-of-range store does not write the array;
  - an out-of-range load returns all zeros;
  - mem_err_o = 1 for the whole of RESP; the handshake is otherwise unchanged.
- Not defined:
  - the index is taken modulo MEM_SIZE (upper bits dropped), so accesses wrap around;
  - mem_err_o is a constant 0.

## Structure
- Package mem_pkg: FSM state enum (IDLE, WAIT, RESP), a function returning line width, and a function returning offset bits.
- Sub-module mem_array: single-port synchronous RAM, MEM_SIZE × LW, with we / addr / wdata / rdata and one-cycle read. Its read is issued one cycle before WAIT exits, so that the read register is captured at counter = 0.
- The top level holds the FSM, latency counter, latched request and tri-state driver.

## Test plan
- Reset mid-WAIT:
  - store to 0x40, assert resetn_i = 0 after one cycle, release;
  - mem_valid_o stays 0 until a new request;
  - a later load from 0x40 returns the prior contents (no write happened).
- Store then load, LATENCY = 2:
  - store 0x0000_0010 with data 128'hDEAD…0001;
  - mem_valid_o rises 2 cycles after acceptance;
  - a later load from 0x10 returns 128'hDEAD…0001, and mem_data_io is driven only while mem_valid_o = 1.
- Hold and release:
  - keep mem_valid_i high 5 cycles in RESP; mem_valid_o and data stay constant;
  - drop mem_valid_i; mem_valid_o is 0 the next cycle.
- Abort:
  - load request, drop mem_valid_i in WAIT; mem_valid_o never asserts;
  - an immediate next store to 0x20 is accepted and completes normally.
- Out of range (line MEM_SIZE, address 0x4000 with defaults):
  - with the macro: store is not written, a load returns 0, mem_err_o = 1;
  - without the macro: the access wraps to line 0 (address 0x0).
